// File: rtl/direction_input_ctrl_if.sv
// Button/display bus for direction_input_ctrl: raw active-low keys in,
// registered direction command out.
interface direction_input_ctrl_if;
  logic [3:0] key_n;
  logic [1:0] direc;
  logic       enable;
  logic       dir_changed;

  modport master (output key_n, input direc, enable, dir_changed);
  modport slave  (input key_n, output direc, enable, dir_changed);
endinterface

// File: rtl/direction_input_ctrl.sv
// Push-button front end for the direction display: per-key sync + debounce,
// fixed-priority select, and an IDLE/ACTIVE/HOLD FSM producing direc/enable.
module dic_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic pressed_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n_i};
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  // Key is active-low, so "levels differ" means sync bit equals pressed.
  always_comb begin
    cnt_d     = '0;
    pressed_d = pressed_q;
    if (~sync_q[1] != pressed_q) begin
      if (cnt_q == CNT_MAX) pressed_d = ~pressed_q;
      else                  cnt_d     = cnt_q + 1'b1;
    end
  end

  assign pressed_o = pressed_q;
endmodule

module direction_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  direction_input_ctrl_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  logic [3:0] pressed;
  logic       any;
  logic [1:0] sel;

  state_t        state_q, state_d;
  logic [1:0]    direc_q, direc_d;
  logic          enable_q, enable_d;
  logic          chg_q, chg_d;
  logic [HW-1:0] hold_q, hold_d;

  for (genvar i = 0; i < 4; i++) begin : g_key
    dic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clk),
      .reset     (reset),
      .key_n_i   (bus.key_n[i]),
      .pressed_o (pressed[i])
    );
  end

  // Lowest index wins: forward > reverse > left > right.
  always_comb begin
    any = |pressed;
    if      (pressed[0]) sel = 2'd0;
    else if (pressed[1]) sel = 2'd1;
    else if (pressed[2]) sel = 2'd2;
    else                 sel = 2'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      direc_q  <= 2'b00;
      enable_q <= 1'b0;
      chg_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      direc_q  <= direc_d;
      enable_q <= enable_d;
      chg_q    <= chg_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    direc_d  = direc_q;
    enable_d = enable_q;
    chg_d    = 1'b0;
    hold_d   = hold_q;
    unique case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (any) begin
          direc_d  = sel;
          enable_d = 1'b1;
          chg_d    = 1'b1;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        enable_d = 1'b1;
        if (any) begin
          direc_d = sel;
          chg_d   = (sel != direc_q);
        end else begin
          hold_d  = HOLD_LOAD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        enable_d = 1'b1;
        // A re-press beats the timeout even on the counter-zero edge.
        if (any) begin
          direc_d = sel;
          chg_d   = (sel != direc_q);
          state_d = ACTIVE;
        end else if (hold_q == '0) begin
          enable_d = 1'b0;
          state_d  = IDLE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.direc       = direc_q;
  assign bus.enable      = enable_q;
  assign bus.dir_changed = chg_q;
endmodule

// File: tb/tb_direction_input_ctrl.sv
// Directed + randomized bench for direction_input_ctrl against a cycle model.
module tb_direction_input_ctrl;
  localparam int D = 4;
  localparam int H = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  direction_input_ctrl_if bus();

  direction_input_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples delayed two edges, a key flips after D
  // disagreeing samples in a row; enable lingers H edges after release.
  bit [3:0]   m_s1, m_s2, m_pr;
  int         run [4];
  bit         m_en, m_hold, m_chg;
  bit [1:0]   m_dir;
  int         rem;

  always @(posedge clk or posedge reset) begin
    bit       any;
    bit [1:0] s;
    if (reset) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_pr = 4'h0;
      for (int i = 0; i < 4; i++) run[i] = 0;
      m_en = 0; m_hold = 0; m_chg = 0; m_dir = 2'b00; rem = 0;
    end else begin
      any = |m_pr;
      s = 2'd3;
      for (int i = 3; i >= 0; i--) if (m_pr[i]) s = 2'(i);
      m_chg = 0;
      if (any) begin
        m_chg  = !m_en || (s != m_dir);
        m_dir  = s;
        m_en   = 1;
        m_hold = 0;
      end else if (m_en && !m_hold) begin
        m_hold = 1;
        rem    = H;
      end else if (m_hold) begin
        rem--;
        if (rem == 0) begin m_en = 0; m_hold = 0; end
      end
      for (int i = 0; i < 4; i++) begin
        if (!m_s2[i] != m_pr[i]) begin
          run[i]++;
          if (run[i] == D) begin m_pr[i] = ~m_pr[i]; run[i] = 0; end
        end else run[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = bus.key_n;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".direc"},  32'(bus.direc),       32'(m_dir));
    chk({tag, ".enable"}, 32'(bus.enable),      32'(m_en));
    chk({tag, ".chg"},    32'(bus.dir_changed), 32'(m_chg));
  endtask

  task automatic cyc(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cmp_model(tag);
    end
  endtask

  initial begin
    int pulses, lows, len;
    bus.key_n = 4'hF;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.direc",  32'(bus.direc),       0);
    chk("rst.enable", 32'(bus.enable),      0);
    chk("rst.chg",    32'(bus.dir_changed), 0);
    cyc(2, "idle");

    // Clean press of left: outputs update on edge 3+D.
    bus.key_n = 4'b1011;
    for (int e = 1; e <= 8; e++) begin
      cyc(1, "press");
      if (e < 7) chk("press.en_early", 32'(bus.enable), 0);
      if (e == 7) begin
        chk("press.direc", 32'(bus.direc), 2);
        chk("press.en",    32'(bus.enable), 1);
        chk("press.chg",   32'(bus.dir_changed), 1);
      end
      if (e == 8) chk("press.chg_off", 32'(bus.dir_changed), 0);
    end
    cyc(3, "held");

    // Release: HOLD entered at edge 7, enable falls at edge 7+H.
    bus.key_n = 4'hF;
    for (int e = 1; e <= 16; e++) begin
      cyc(1, "release");
      if (e == 14) chk("release.en_hi", 32'(bus.enable), 1);
      if (e == 15) chk("release.en_lo", 32'(bus.enable), 0);
    end

    // Bounce on right shorter than D samples.
    for (int g = 0; g < 4; g++) begin
      len = $urandom_range(1, D - 1);
      bus.key_n[3] = 1'b0;
      for (int c = 0; c < len; c++) begin
        cyc(1, "bounce");
        chk("bounce.en",  32'(bus.enable), 0);
        chk("bounce.chg", 32'(bus.dir_changed), 0);
      end
      bus.key_n[3] = 1'b1;
      cyc($urandom_range(1, 3), "bounce_gap");
    end
    cyc(8, "bounce_tail");
    chk("bounce.en_end", 32'(bus.enable), 0);

    // Priority and swap.
    bus.key_n = 4'b0111;
    cyc(8, "right");
    chk("right.direc", 32'(bus.direc), 3);
    bus.key_n = 4'b0110;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin cyc(1, "fwd_over"); pulses += int'(bus.dir_changed); end
    chk("swap1.pulses", 32'(pulses), 1);
    chk("swap1.direc",  32'(bus.direc), 0);
    bus.key_n = 4'b0111;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin cyc(1, "fwd_rel"); pulses += int'(bus.dir_changed); end
    chk("swap2.pulses", 32'(pulses), 1);
    chk("swap2.direc",  32'(bus.direc), 3);
    bus.key_n = 4'hF;
    cyc(20, "drain1");

    // Re-press reverse with three hold cycles left.
    bus.key_n = 4'b1101;
    cyc(8, "rev");
    chk("rev.direc", 32'(bus.direc), 1);
    bus.key_n = 4'hF;
    pulses = 0; lows = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(1, "rev_rel");
      pulses += int'(bus.dir_changed); lows += int'(!bus.enable);
    end
    bus.key_n = 4'b1101;
    for (int c = 0; c < 12; c++) begin
      cyc(1, "rev_re");
      pulses += int'(bus.dir_changed); lows += int'(!bus.enable);
    end
    chk("repress.lows",   32'(lows), 0);
    chk("repress.pulses", 32'(pulses), 0);
    chk("repress.direc",  32'(bus.direc), 1);
    bus.key_n = 4'hF;
    cyc(20, "drain2");

    // Press debounces exactly on the hold-counter-zero edge.
    bus.key_n = 4'b1110;
    cyc(8, "fwd");
    bus.key_n = 4'hF;
    lows = 0;
    for (int c = 0; c < 8; c++) begin cyc(1, "col_rel"); lows += int'(!bus.enable); end
    bus.key_n = 4'b1110;
    for (int c = 0; c < 12; c++) begin cyc(1, "col_press"); lows += int'(!bus.enable); end
    chk("collide.lows", 32'(lows), 0);
    bus.key_n = 4'hF;
    cyc(20, "drain3");

    // Randomized key patterns against the model.
    for (int seg = 0; seg < 40; seg++) begin
      bus.key_n = 4'($urandom_range(0, 15));
      cyc($urandom_range(1, 14), "rand");
    end
    bus.key_n = 4'hF;
    cyc(20, "drain4");

    // Asynchronous reset while ACTIVE with direc=10.
    bus.key_n = 4'b1011;
    cyc(8, "pre_rst");
    chk("pre_rst.direc", 32'(bus.direc), 2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst.direc",  32'(bus.direc), 0);
    chk("async_rst.enable", 32'(bus.enable), 0);
    chk("async_rst.chg",    32'(bus.dir_changed), 0);
    @(negedge clk);
    bus.key_n = 4'hF;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      cyc(1, "post_rst");
      chk("post_rst.direc", 32'(bus.direc), 0);
      chk("post_rst.en",    32'(bus.enable), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/direction_input_ctrl.md
# direction_input_ctrl

Upstream command stage for the direction display. It synchronises and debounces four active-low push-buttons (forward, reverse, left, right) and resolves simultaneous presses by fixed priority. A hold/timeout state machine turns the result into the registered `direc[1:0]` / `enable` pair consumed by `seven_seg`. It also emits a one-cycle pulse whenever the displayed command changes.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a key's debounced state flips (10 ms at 50 MHz). Must be ≥1.
- `HOLD_CYCLES`, default 25000000: cycles `enable` stays asserted after all keys are released (0.5 s at 50 MHz). Must be ≥1.
- `clk`  input  1: system clock, 50 MHz. All state is updated on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `key_n`  input  4: raw active-low buttons, asynchronous to `clk`. Bit i requests direction code i: 0 = forward (00), 1 = reverse (01), 2 = left (10), 3 = right (11).
- `direc`  output  2: registered direction code, fed to `seven_seg.direc`.
- `enable`  output  1: registered display enable, fed to `seven_seg.enable`.
- `dir_changed`  output  1: one-cycle registered pulse when a command becomes valid or its code changes.

## Operation
- **Synchroniser:** two flip-flops per key. Both reset to 1 (released).
- **Debounce, per key:**
  - A counter of width `$clog2(DEBOUNCE_CYCLES+1)` increments while the synchronised level differs from the debounced level. It clears to 0 whenever the two levels are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the levels still differ, the debounced level flips and the counter clears.
  - The debounced level is stored active-high as `pressed[i]`, reset value 0.
- **Priority:** when several keys are pressed, the lowest index wins (forward > reverse > left > right). `sel` is the code of the highest-priority pressed key. `any` is the OR of `pressed`.
- **FSM states: IDLE, ACTIVE, HOLD.** The reset state is IDLE.
  - IDLE:
    - `enable`=0, `direc` holds its last value.
    - If `any`: `direc`<=`sel`, `enable`<=1, `dir_changed`<=1, go to ACTIVE.
  - ACTIVE:
    - `enable`=1.
    - If `any`: `direc`<=`sel`. `dir_changed`<=1 only if `sel` differs from the current `direc`.
    - If not `any`: load the hold counter with `HOLD_CYCLES-1` and go to HOLD. `direc` is unchanged.
  - HOLD:
    - `enable`=1, `direc` unchanged.
    - If `any`: `direc`<=`sel`, with a `dir_changed` pulse if the code differs. Go to ACTIVE. A re-press always takes precedence over the timeout.
    - Else if the hold counter = 0: `enable`<=0, go to IDLE.
    - Else: decrement the hold counter.
- **Outputs:** all are driven directly from flip-flops, with no combinational path from `key_n`. Outside the cases listed above, `dir_changed`=0.

## Timing
- **Reset values:** `direc`=00, `enable`=0, `dir_changed`=0, all debounce and hold counters = 0, all `pressed` = 0, synchronisers = 1111.
- **Reset mid-operation:** outputs return to their reset values immediately, without waiting for a clock edge. After release, a key that is still held is treated as a fresh press and needs the full debounce time.
- **Press latency:** a clean level change sampled at edge 1 is visible after synchronisation at edge 2. `pressed` flips at edge 2+`DEBOUNCE_CYCLES`. `direc`, `enable` and `dir_changed` update at edge 3+`DEBOUNCE_CYCLES`.
- **Glitch rejection:** a bounce or glitch lasting fewer than `DEBOUNCE_CYCLES` synchronised cycles never changes `pressed`.
- **Release timing:** let R be the edge at which ACTIVE moves to HOLD. `enable` stays 1 through edge R+`HOLD_CYCLES`-1 and falls at edge R+`HOLD_CYCLES`. `enable` is therefore high for exactly `HOLD_CYCLES` cycles of HOLD.
- **Same-edge events:** if a press becomes debounced on the same edge as the timeout (`any` while the hold counter = 0), the press wins. The FSM goes to ACTIVE and `enable` never drops.
- **Key swap within one edge:** if one key is released and another becomes pressed on the same edge, the FSM stays in ACTIVE and `direc` switches with a single `dir_changed` pulse.
- **Pulse width:** `dir_changed` is never high for two consecutive cycles unless the code changes on both cycles.

## Test plan
Use `DEBOUNCE_CYCLES`=4 and `HOLD_CYCLES`=8 throughout.
- **Reset:** assert `reset` mid-cycle while in ACTIVE with `direc`=10 -> `direc`=00 and `enable`=0 immediately. After release with `key_n`=1111, the outputs stay at reset values for 20 cycles.
- **Clean press and hold:** `key_n`=1011 (left) held → at edge 7 `direc`=10, `enable`=1, one-cycle `dir_changed`=1. Release → `enable` falls exactly 8 cycles after the FSM enters HOLD.
- **Bounce rejection:** toggle `key_n[3]` low for 3 cycles, then high → `pressed`, `enable` and `dir_changed` never change.
- **Priority and swap:** hold right (0111), then also press forward (0110) → `direc` goes 11 → 00 with one `dir_changed` pulse. Release forward → `direc`=11 and a second pulse.
- **Re-press during hold:** release reverse, then re-press reverse while 3 hold cycles remain → `enable` stays 1, `direc` stays 01, no `dir_changed` pulse.
- **Timeout/press collision:** time a press so that it debounces exactly on the hold-counter-zero edge → FSM goes to ACTIVE and `enable` has no low cycle.
